pattern_mode_sel: RTL
=====================

Name: pattern_mode_sel

Overview:
Upstream control stage for the VGA colour-bar generator. It drives that generator's 2-bit pattern-select input (switch) from a debounced push button, with an optional auto-cycle mode. Mode changes are applied only at a frame boundary (vsync falling edge), so a frame never shows two patterns. It runs on the same 50 MHz board clock as the VGA block.

Parameters:
DB_CYCLES, 1000000, number of consecutive stable clock cycles a key level must hold before it is accepted (20 ms at 50 MHz); minimum value 2.
AUTO_FRAMES, 120, number of frame boundaries between automatic advances (2 s at 60 Hz); minimum value 1.

Ports:
clock  input  1  50 MHz board clock; all logic is on its rising edge.
reset_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
key_n  input  1  raw push button, active-low, asynchronous and bouncy.
auto_en  input  1  raw slide switch, asynchronous; 1 enables auto-cycling.
vsync  input  1  vsync from the VGA timing block, active-low sync pulse, asynchronous to this block.
switch  output  2  pattern select to the VGA block: 0 = horizontal bars, 1 = vertical bars, 2 = XOR, 3 = XNOR.
mode_changed  output  1  one-cycle pulse on the same edge that switch changes.

Behaviour:
- Reset (async, reset_n=0) values:
  - switch=0, mode_changed=0, frame_cnt=0, pending=0, debounce FSM=RELEASED, debounce counter=0.
  - key_n and vsync synchroniser flops reset to 1; auto_en synchroniser flops reset to 0. This prevents false edges after reset.
  - Reset asserted mid-debounce or mid-count discards all progress.
- Synchronisers: two flops on each of key_n, auto_en and vsync. A third flop on synced vsync provides edge detect.
- Frame boundary: a one-cycle strobe fb = (vs_s3 == 1 && vs_s2 == 0).
  - With vsync falling before edge k, fb is high in the cycle after edge k+1, and switch updates at edge k+2.
- Debounce FSM, on synced key k_s:
  - RELEASED: if k_s=0, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if k_s=1, return to RELEASED. Otherwise cnt++; when cnt == DB_CYCLES-1, go to PRESSED and raise a one-cycle press strobe.
  - PRESSED: if k_s=1, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT: if k_s=0, return to PRESSED. Otherwise cnt++; when cnt == DB_CYCLES-1, go to RELEASED (no strobe).
  - Counter width is clog2(DB_CYCLES). A glitch shorter than DB_CYCLES produces no strobe.
- pending flag: set by the press strobe, cleared when consumed. Multiple presses within one frame produce a single advance. Define pend_eff = pending | press.
- On fb:
  - If pend_eff: switch <= switch+1, wrapping 3 to 0 (modulo 4); clear pending; clear frame_cnt; pulse mode_changed.
  - Else if auto_en synced is 1 and frame_cnt == AUTO_FRAMES-1: switch <= switch+1; clear frame_cnt; pulse mode_changed.
  - Else if auto_en synced is 1: frame_cnt++.
- Simultaneous press and auto expiry on the same fb: a single advance only.
- A press strobe in the same cycle as fb is applied on that fb.
- auto_en synced at 0 holds frame_cnt at 0, so re-enabling auto always waits the full AUTO_FRAMES.
- frame_cnt width is clog2(AUTO_FRAMES)+1.
- switch and mode_changed are registered outputs with no combinational path from any input.

Decomposition:
- vga_pkg holds:
  - the mode encodings MODE_HBARS=0, MODE_VBARS=1, MODE_XOR=2, MODE_XNOR=3, shared with the VGA block;
  - the debounce FSM state typedef (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
- Sub-module key_debounce contains the key synchroniser, the FSM, the counter and the press strobe, parameterised by DB_CYCLES. It will be reused for the other board keys.

Test Plan (bench uses DB_CYCLES=8, AUTO_FRAMES=3, vsync low 2 cycles every 40 cycles):
1. Reset: assert reset_n=0 mid-frame -> switch=0 and mode_changed=0 immediately; no mode_changed pulse for 5 frames after release with key_n=1 and auto_en=0.
2. Clean press: key_n low for 20 cycles -> exactly one mode_changed pulse, at the first fb after the strobe, with switch 0 to 1; switch does not change before that fb.
3. Bounce: key_n toggles every 3 cycles for 30 cycles, then is held low -> exactly one advance; a 5-cycle low glitch alone -> no advance.
4. Multiple presses: three debounced presses between two fb strobes -> one advance. Four separate frames, each with one press -> switch goes 1, 2, 3, 0 (wrap).
5. Auto mode: auto_en=1 from switch=0 -> advance on every 3rd fb (switch 1, 2, 3, 0 across 12 fbs). auto_en dropped after 2 fbs and re-raised -> the count restarts from 0.
6. Coincidence: a press strobe timed on the same cycle as the fb that expires auto -> single advance (+1 only), frame_cnt=0, one mode_changed pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour-bar generator and its control logic.
// Holds the pattern-select encodings and the key debounce state encoding.
package vga_pkg;

    // Pattern select codes understood by the VGA block
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HBARS = 2'd0;
    localparam mode_t MODE_VBARS = 2'd1;
    localparam mode_t MODE_XOR   = 2'd2;
    localparam mode_t MODE_XNOR  = 2'd3;

    // Debounce FSM states
    typedef logic [1:0] db_state_t;

    localparam db_state_t RELEASED     = 2'd0;
    localparam db_state_t PRESS_WAIT   = 2'd1;
    localparam db_state_t PRESSED      = 2'd2;
    localparam db_state_t RELEASE_WAIT = 2'd3;

    // Next pattern in the cycle; XNOR wraps back to horizontal bars
    function automatic mode_t next_mode(input mode_t m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises a raw active-low key and emits a
// one-cycle press strobe once a low level has held for DB_CYCLES.
// Ports: clock, reset_n (async active-low), key_n (raw, active-low),
//        press (one-cycle strobe on an accepted press).
module key_debounce
    import vga_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          k_s1;
    logic          k_s2;
    db_state_t     state;
    logic [CW-1:0] cnt;

    // Synchroniser idles high so reset never looks like a press
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k_s1 <= 1'b1;
            k_s2 <= 1'b1;
        end else begin
            k_s1 <= key_n;
            k_s2 <= k_s1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            unique case (state)
                RELEASED: begin
                    if (!k_s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (k_s2) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (k_s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!k_s2) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pattern_mode_sel.sv
// Pattern selector for the VGA colour-bar generator: advances on a debounced
// key press or on an auto-cycle timer, only ever at a vsync falling edge.
// Ports: clock, reset_n (async active-low), key_n, auto_en, vsync (all raw),
//        switch (pattern select), mode_changed (pulse when switch changes).
module pattern_mode_sel
    import vga_pkg::*;
#(
    parameter int DB_CYCLES   = 1000000,
    parameter int AUTO_FRAMES = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_n,
    input  logic       auto_en,
    input  logic       vsync,
    output logic [1:0] switch,
    output logic       mode_changed
);

    localparam int FW = $clog2(AUTO_FRAMES) + 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

    logic          press;
    logic          au_s1;
    logic          au_s2;
    logic          vs_s1;
    logic          vs_s2;
    logic          vs_s3;
    logic          fb;
    logic          pending;
    logic          pend_eff;
    logic          expire;
    logic [FW-1:0] frame_cnt;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_n),
        .press   (press)
    );

    // vsync idles high and auto_en low out of reset: no false edges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            au_s1 <= 1'b0;
            au_s2 <= 1'b0;
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_s3 <= 1'b1;
        end else begin
            au_s1 <= auto_en;
            au_s2 <= au_s1;
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign fb       = vs_s3 & ~vs_s2;
    // A strobe landing on the boundary cycle is applied right away
    assign pend_eff = pending | press;
    assign expire   = au_s2 && (frame_cnt == FRAME_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch       <= MODE_HBARS;
            mode_changed <= 1'b0;
            pending      <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            mode_changed <= 1'b0;
            pending      <= pend_eff;
            // Auto off pins the count so re-enable waits a full period
            if (!au_s2) begin
                frame_cnt <= '0;
            end
            if (fb) begin
                pending <= 1'b0;
                if (pend_eff || expire) begin
                    switch       <= next_mode(switch);
                    frame_cnt    <= '0;
                    mode_changed <= 1'b1;
                end else if (au_s2) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule
